// File: rtl/vdf_seq_pkg.sv
// Shared types and defaults for the VDF squaring sequencer.
// Optional feature macro used by this slice: VDF_SEQ_CKPT_EN (checkpoint pulses).
package vdf_seq_pkg;

    localparam int NUM_ELEMENTS_DEF = 62;
    localparam int BIT_LEN_DEF      = 18;
    localparam int WORD_LEN_DEF     = 17;
    localparam int ITER_W_DEF       = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Redundant-form operand at the default geometry, limb 0 in the low bits.
    typedef logic [NUM_ELEMENTS_DEF-1:0][BIT_LEN_DEF-1:0] limb_vec_t;

endpackage

// File: rtl/vdf_iter_counter.sv
// Iteration counter for the VDF sequencer: owns cnt and the latched target n,
// flags the last iteration and, with VDF_SEQ_CKPT_EN defined, detects checkpoints.
module vdf_iter_counter
    import vdf_seq_pkg::*;
#(
    parameter int ITER_W        = ITER_W_DEF,
    parameter int CKPT_INTERVAL = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_load,
    input  logic [ITER_W-1:0] i_n,
    input  logic              i_inc,
    output logic [ITER_W-1:0] o_cnt,
    output logic              o_last,
    output logic              o_ckpt_valid,
    output logic [ITER_W-1:0] o_ckpt_iter
);

    logic [ITER_W-1:0] r_cnt;
    logic [ITER_W-1:0] r_n;
    logic [ITER_W-1:0] w_cnt_nxt;

    assign w_cnt_nxt = r_cnt + ITER_W'(1);
    assign o_cnt     = r_cnt;
    assign o_last    = (w_cnt_nxt == r_n);

    // Clear on job accept, advance once per committed squaring.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_n   <= '0;
        end else if (i_load) begin
            r_cnt <= '0;
            r_n   <= i_n;
        end else if (i_inc) begin
            r_cnt <= w_cnt_nxt;
        end
    end

`ifdef VDF_SEQ_CKPT_EN
    localparam logic [ITER_W-1:0] CKPT_MASK = ITER_W'(CKPT_INTERVAL - 1);

    logic r_ckpt_valid;
    logic w_ckpt_hit;

    // w_cnt_nxt is never zero here because cnt never reaches the wrap point.
    assign w_ckpt_hit = ((w_cnt_nxt & CKPT_MASK) == '0) && (w_cnt_nxt < r_n);

    // One-cycle pulse following an increment that lands on a checkpoint.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ckpt_valid <= 1'b0;
        end else begin
            r_ckpt_valid <= i_inc && !i_load && w_ckpt_hit;
        end
    end

    assign o_ckpt_valid = r_ckpt_valid;
    assign o_ckpt_iter  = r_cnt;
`else
    assign o_ckpt_valid = 1'b0;
    assign o_ckpt_iter  = '0;
`endif

endmodule

// File: rtl/vdf_square_sequencer.sv
// Job-level controller feeding an external combinational modular-squaring ALU.
// Accepts a job, iterates acc <= alu_ms once per cycle, supports abort and holds
// the result until consumed. Optional checkpoint pulses under VDF_SEQ_CKPT_EN.
module vdf_square_sequencer
    import vdf_seq_pkg::*;
#(
    parameter int NUM_ELEMENTS  = NUM_ELEMENTS_DEF,
    parameter int BIT_LEN       = BIT_LEN_DEF,
    parameter int WORD_LEN      = WORD_LEN_DEF,
    parameter int ITER_W        = ITER_W_DEF,
    parameter int CKPT_INTERVAL = 1024
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            job_valid,
    output logic                            job_ready,
    input  logic [BIT_LEN*NUM_ELEMENTS-1:0] job_a,
    input  logic [ITER_W-1:0]               job_iters,
    input  logic                            abort,
    output logic [BIT_LEN*NUM_ELEMENTS-1:0] alu_a,
    input  logic [BIT_LEN*NUM_ELEMENTS-1:0] alu_ms,
    output logic                            res_valid,
    input  logic                            res_ready,
    output logic [BIT_LEN*NUM_ELEMENTS-1:0] res_ms,
    output logic [ITER_W-1:0]               res_iters_done,
    output logic                            res_aborted,
    output logic                            busy,
    output logic                            ckpt_valid,
    output logic [ITER_W-1:0]               ckpt_iter
);

    localparam int VEC_W = BIT_LEN * NUM_ELEMENTS;

    seq_state_e         r_state;
    logic [VEC_W-1:0]   r_acc;
    logic               r_res_valid;
    logic               r_busy;
    logic               r_aborted;
    logic               w_accept;
    logic               w_inc;
    logic               w_last;
    logic [ITER_W-1:0]  w_cnt;

    assign w_accept = (r_state == IDLE) && job_valid;
    assign w_inc    = (r_state == RUN) && !abort;

    vdf_iter_counter #(
        .ITER_W        (ITER_W),
        .CKPT_INTERVAL (CKPT_INTERVAL)
    ) u_cnt (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_load       (w_accept),
        .i_n          (job_iters),
        .i_inc        (w_inc),
        .o_cnt        (w_cnt),
        .o_last       (w_last),
        .o_ckpt_valid (ckpt_valid),
        .o_ckpt_iter  (ckpt_iter)
    );

    // Job FSM with registered status outputs and the working register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_res_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_aborted   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (job_valid) begin
                        r_acc     <= job_a;
                        r_aborted <= 1'b0;
                        r_busy    <= 1'b1;
                        if (job_iters == '0) begin
                            r_state     <= DONE;
                            r_res_valid <= 1'b1;
                        end else begin
                            r_state <= RUN;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        r_aborted   <= 1'b1;
                        r_state     <= DONE;
                        r_res_valid <= 1'b1;
                    end else begin
                        r_acc <= alu_ms;
                        if (w_last) begin
                            r_state     <= DONE;
                            r_res_valid <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        r_state     <= IDLE;
                        r_res_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_res_valid <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign job_ready      = (r_state == IDLE);
    assign alu_a          = r_acc;
    assign res_ms         = r_acc;
    assign res_valid      = r_res_valid;
    assign busy           = r_busy;
    assign res_aborted    = r_aborted;
    assign res_iters_done = w_cnt;

endmodule

// File: tb/tb_vdf_square_sequencer.sv
// Directed bench for vdf_square_sequencer with a stub ALU (each limb + 1).
// Expected results are queued at job submission and checked when res_valid rises.
module tb_vdf_square_sequencer;
    import vdf_seq_pkg::*;

    localparam int NE    = 62;
    localparam int BL    = 18;
    localparam int IW    = 32;
    localparam int CKI   = 4;
    localparam int VEC_W = NE * BL;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             job_valid = 1'b0;
    logic             job_ready;
    logic [VEC_W-1:0] job_a = '0;
    logic [IW-1:0]    job_iters = '0;
    logic             abort = 1'b0;
    logic [VEC_W-1:0] alu_a;
    logic [VEC_W-1:0] alu_ms;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [VEC_W-1:0] res_ms;
    logic [IW-1:0]    res_iters_done;
    logic             res_aborted;
    logic             busy;
    logic             ckpt_valid;
    logic [IW-1:0]    ckpt_iter;

    typedef struct {
        logic [BL-1:0] limb;
        logic [IW-1:0] iters;
        logic          aborted;
        int            latency;
    } exp_t;

    exp_t          sb[$];
    logic [IW-1:0] ckpt_seen[$];
    int            ckpt_bad_val = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    int            edges = 0;

    always #5 clk = ~clk;

    vdf_square_sequencer #(
        .NUM_ELEMENTS  (NE),
        .BIT_LEN       (BL),
        .WORD_LEN      (17),
        .ITER_W        (IW),
        .CKPT_INTERVAL (CKI)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .job_valid      (job_valid),
        .job_ready      (job_ready),
        .job_a          (job_a),
        .job_iters      (job_iters),
        .abort          (abort),
        .alu_a          (alu_a),
        .alu_ms         (alu_ms),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_ms         (res_ms),
        .res_iters_done (res_iters_done),
        .res_aborted    (res_aborted),
        .busy           (busy),
        .ckpt_valid     (ckpt_valid),
        .ckpt_iter      (ckpt_iter)
    );

    // Stub squaring ALU: every limb incremented, wrapping at the limb width.
    always_comb begin
        alu_ms = '0;
        for (int unsigned i = 0; i < NE; i++) begin
            alu_ms[i*BL +: BL] = alu_a[i*BL +: BL] + BL'(1);
        end
    end

    // Checkpoint monitor: record every pulse and its snapshot consistency.
    always @(negedge clk) begin
        if (rst_n && ckpt_valid) begin
            ckpt_seen.push_back(ckpt_iter);
            if (res_ms[BL-1:0] !== BL'(5 + ckpt_iter)) ckpt_bad_val++;
        end
    end

    function automatic logic [VEC_W-1:0] fill(input logic [BL-1:0] v);
        logic [VEC_W-1:0] f;
        for (int unsigned i = 0; i < NE; i++) f[i*BL +: BL] = v;
        return f;
    endfunction

    task automatic chk(input string tag, input logic [IW-1:0] obs, input logic [IW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_vec(input string tag, input logic [VEC_W-1:0] obs, input logic [VEC_W-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed limb0 %0d expected limb0 %0d", tag, obs[BL-1:0], exp[BL-1:0]);
        end
    endtask

    task automatic step();
        @(negedge clk);
        edges++;
    endtask

    // Offer a job; returns at the negedge just after the accepting edge (edges = 0).
    task automatic start_job(input logic [BL-1:0] a, input logic [IW-1:0] n,
                             input logic [IW-1:0] exp_iters, input logic exp_abort,
                             input int exp_lat);
        exp_t e;
        @(negedge clk);
        chk("job_ready_idle", IW'(job_ready), 1);
        job_valid = 1'b1;
        job_a     = fill(a);
        job_iters = n;
        e.limb    = a + BL'(exp_iters);
        e.iters   = exp_iters;
        e.aborted = exp_abort;
        e.latency = exp_lat;
        sb.push_back(e);
        @(negedge clk);
        job_valid = 1'b0;
        edges = 0;
    endtask

    // Wait for res_valid, check against the scoreboard, then hold and hand off.
    task automatic finish_job(input int hold);
        exp_t e;
        logic [VEC_W-1:0] snap;
        while (!res_valid && edges < 2000) step();
        e = sb.pop_front();
        chk("latency", IW'(edges), IW'(e.latency));
        chk_vec("res_ms", res_ms, fill(e.limb));
        chk("res_iters_done", res_iters_done, e.iters);
        chk("res_aborted", IW'(res_aborted), IW'(e.aborted));
        snap = res_ms;
        if (hold > 0) begin
            job_valid = 1'b1;
            job_iters = 7;
            job_a     = fill(BL'(99));
            abort     = 1'b1;
            for (int i = 0; i < hold; i++) step();
            abort = 1'b0;
            chk_vec("done_hold_ms", res_ms, snap);
            chk("done_hold_valid", IW'(res_valid), 1);
            chk("done_hold_ready", IW'(job_ready), 0);
            chk("done_hold_iters", res_iters_done, e.iters);
        end
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("post_hs_valid", IW'(res_valid), 0);
        chk("post_hs_busy", IW'(busy), 0);
        chk("post_hs_job_ready", IW'(job_ready), 1);
        job_valid = 1'b0;
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_res_valid", IW'(res_valid), 0);
        chk("rst_busy", IW'(busy), 0);
        chk("rst_aborted", IW'(res_aborted), 0);
        chk("rst_iters", res_iters_done, 0);
        chk("rst_ckpt", IW'(ckpt_valid), 0);
        chk_vec("rst_alu_a", alu_a, '0);
        chk_vec("rst_res_ms", res_ms, '0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_job_ready", IW'(job_ready), 1);

        // Basic N=3
        start_job(BL'(5), 3, 3, 1'b0, 3);
        chk("run_busy", IW'(busy), 1);
        chk("run_job_ready", IW'(job_ready), 0);
        finish_job(0);

        // N=0 passes the start value straight through
        start_job(BL'(5), 0, 0, 1'b0, 0);
        finish_job(0);

        // Abort after 40 committed squarings
        start_job(BL'(5), 100, 40, 1'b1, 41);
        for (int i = 0; i < 40; i++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        finish_job(0);

        // Abort coincident with the final iteration
        start_job(BL'(5), 5, 4, 1'b1, 5);
        for (int i = 0; i < 4; i++) step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        finish_job(0);

        // Result held 10 cycles while a job and abort are offered
        start_job(BL'(20), 6, 6, 1'b0, 6);
        finish_job(10);

        // Checkpoints with interval 4, N=12
        ckpt_seen.delete();
        ckpt_bad_val = 0;
        start_job(BL'(5), 12, 12, 1'b0, 12);
        finish_job(0);
`ifdef VDF_SEQ_CKPT_EN
        chk("ckpt_count", IW'(ckpt_seen.size()), 2);
        if (ckpt_seen.size() == 2) begin
            chk("ckpt_iter0", ckpt_seen[0], 4);
            chk("ckpt_iter1", ckpt_seen[1], 8);
        end
        chk("ckpt_snapshot", IW'(ckpt_bad_val), 0);
`else
        chk("ckpt_never", IW'(ckpt_seen.size()), 0);
`endif

        // Asynchronous reset mid-RUN drops the job
        start_job(BL'(5), 50, 0, 1'b0, 0);
        for (int i = 0; i < 10; i++) step();
        #2 rst_n = 1'b0;
        #1;
        chk("arst_busy", IW'(busy), 0);
        chk("arst_res_valid", IW'(res_valid), 0);
        chk("arst_job_ready", IW'(job_ready), 1);
        chk("arst_iters", res_iters_done, 0);
        void'(sb.pop_front());
        #1 rst_n = 1'b1;
        start_job(BL'(7), 3, 3, 1'b0, 3);
        finish_job(0);

        chk("sb_empty", IW'(sb.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
